// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: operation and state encodings
// plus the default operand width.
package mdu_defs;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MUL    = 2'b01,
    ST_DIV    = 2'b10,
    ST_FINISH = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply/divide unit with architectural HI/LO registers.
// Multiply and divide share one counter, one accumulator and one shift register.
module mult_div_unit
  import mdu_defs::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   acc_s;
  logic             last_s;
  mdu_op_e          op_s;

  assign op_s = mdu_op_e'(MDOp);

  // Next-state, datapath iteration and HI/LO update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = 1'b0;
    acc_s   = '0;
    last_s  = (cnt_q == CNT_W'(WIDTH - 1));
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          cnt_d = '0;
          acc_d = '0;
          case (op_s)
            OP_MULTU: begin
              opnd_d  = A;
              sr_d    = B;
              state_d = ST_MUL;
            end
            OP_DIVU: begin
              opnd_d = B;
              sr_d   = A;
              if (B == '0) begin
                state_d = ST_FINISH;
                dbz_d   = 1'b1;
              end else begin
                state_d = ST_DIV;
              end
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        // Add multiplicand when the low multiplier bit is set, then shift {acc,sr} right.
        acc_s = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        acc_d = acc_s[WIDTH:1];
        sr_d  = {acc_s[0], sr_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_s) begin
          state_d = ST_FINISH;
          hi_d    = acc_d;
          lo_d    = sr_d;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DIV: begin
        // Trial subtract of the divisor; the top bit of the difference is the borrow.
        acc_s = {acc_q, sr_q[WIDTH-1]} - {1'b0, opnd_q};
        if (!acc_s[WIDTH]) begin
          acc_d = acc_s[WIDTH-1:0];
          sr_d  = {sr_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[WIDTH-2:0], sr_q[WIDTH-1]};
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (last_s) begin
          state_d = ST_FINISH;
          hi_d    = acc_d;
          lo_d    = sr_d;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sr_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule
